// File: rtl/ldpc_ber_tester_dout_checker_pkg.sv
// Shared types and helpers for the BER tester DOUT checker.
// Holds the block-tracking FSM encoding, the counter width default and a saturating add.
package ldpc_ber_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_BLOCK = 1'b1
    } fsm_state_t;

    localparam int CNT_WIDTH_DEF = 64;

    // Operands are zero-extended to 64 bits; lim is the all-ones value of the caller's counter width.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] lim);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/ldpc_ber_tester_dout_checker_if.sv
// AXI-Stream style DOUT bus between the LDPC decoder and the BER checker.
// master drives the beat, slave returns tready.
interface ldpc_ber_tester_dout_checker_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/ldpc_ber_tester_dout_checker_popcount.sv
// Counts set bits of one beat; 1-cycle latency, no flow control (pipeline valid kept by the caller).
// Output width $clog2(W)+1 holds the all-ones count.
module ldpc_ber_popcount #(
    parameter int W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         din,
    output logic [$clog2(W):0]   cnt
);
    logic [$clog2(W):0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum = sum + ($clog2(W)+1)'(din[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= sum;
    end

endmodule

// File: rtl/ldpc_ber_tester_dout_checker.sv
// DOUT sink for the BER tester: counts bit/block errors of an all-zero codeword stream and checks block length.
// Latency: statistics reflect a beat 3 cycles after acceptance. Never back-pressures once out of reset.
module ldpc_ber_tester_dout_checker
    import ldpc_ber_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [LEN_WIDTH-1:0]  block_beats,
    ldpc_ber_tester_dout_checker_if.slave dout,
    output logic                  dout_finish,
    output logic [CNT_WIDTH-1:0]  bit_errors,
    output logic [CNT_WIDTH-1:0]  bits_checked,
    output logic [CNT_WIDTH-1:0]  block_errors,
    output logic [CNT_WIDTH-1:0]  blocks_checked,
    output logic [CNT_WIDTH-1:0]  worst_block_errs,
    output logic                  length_error
);
    localparam int KW  = DATA_WIDTH / 8;
    localparam int KCW = $clog2(KW) + 1;
    localparam int PW  = $clog2(DATA_WIDTH) + 1;
    localparam logic [63:0] CMAX = 64'({CNT_WIDTH{1'b1}});

    logic                  tready_r;
    logic                  beat_acc;
    logic [DATA_WIDTH-1:0] masked_dat;
    logic [KCW-1:0]        keep_cnt;
    logic                  len_mis;

    fsm_state_t            state;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [LEN_WIDTH-1:0]  beats_lat;

    logic                  s1_vld, s1_last, s1_lerr;
    logic [PW-1:0]         s1_bits;
    logic [DATA_WIDTH-1:0] s1_dat;
    logic                  s2_vld, s2_last, s2_lerr;
    logic [PW-1:0]         s2_bits;
    logic [PW-1:0]         s2_errs;
    logic [CNT_WIDTH-1:0]  acc;
    logic [CNT_WIDTH-1:0]  blk_sum;

    assign dout.tready = tready_r;
    assign beat_acc    = dout.tvalid & tready_r;
    assign dout_finish = beat_acc & dout.tlast;
    assign keep_cnt    = KCW'($countones(dout.tkeep));

    always_comb begin
        masked_dat = '0;
        for (int b = 0; b < KW; b++) begin
            masked_dat[b*8 +: 8] = dout.tdata[b*8 +: 8] & {8{dout.tkeep[b]}};
        end
    end

    // Extra bit avoids wrap when the beat counter has saturated.
    always_comb begin
        len_mis = 1'b0;
        if (dout.tlast) begin
            if (state == IDLE) len_mis = (block_beats != LEN_WIDTH'(1));
            else               len_mis = (({1'b0, beat_cnt} + 1'b1) != {1'b0, beats_lat});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tready_r <= 1'b0;
        else       tready_r <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            beats_lat <= '0;
        end else if (clear) begin
            state <= IDLE;
        end else if (beat_acc) begin
            if (dout.tlast) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                state     <= IN_BLOCK;
                beat_cnt  <= LEN_WIDTH'(1);
                beats_lat <= block_beats;
            end else if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Length verdict travels with the beat so it lands together with the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_lerr <= 1'b0;
            s1_bits <= '0;
            s1_dat  <= '0;
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_lerr <= 1'b0;
            s2_bits <= '0;
        end else begin
            s1_vld  <= beat_acc & ~clear;
            s1_last <= dout.tlast;
            s1_lerr <= len_mis;
            s1_bits <= {keep_cnt, 3'b000};
            s1_dat  <= masked_dat;
            s2_vld  <= s1_vld & ~clear;
            s2_last <= s1_last;
            s2_lerr <= s1_lerr;
            s2_bits <= s1_bits;
        end
    end

    ldpc_ber_popcount #(.W(DATA_WIDTH)) u_popcnt (
        .clk   (clk),
        .reset (reset),
        .din   (s1_dat),
        .cnt   (s2_errs)
    );

    assign blk_sum = CNT_WIDTH'(sat_add(64'(acc), 64'(s2_errs), CMAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            acc              <= '0;
            bit_errors       <= '0;
            bits_checked     <= '0;
            block_errors     <= '0;
            blocks_checked   <= '0;
            worst_block_errs <= '0;
            length_error     <= 1'b0;
        end else if (s2_vld) begin
            bit_errors   <= CNT_WIDTH'(sat_add(64'(bit_errors), 64'(s2_errs), CMAX));
            bits_checked <= CNT_WIDTH'(sat_add(64'(bits_checked), 64'(s2_bits), CMAX));
            if (s2_last) begin
                acc            <= '0;
                blocks_checked <= CNT_WIDTH'(sat_add(64'(blocks_checked), 64'd1, CMAX));
                if (blk_sum != '0)
                    block_errors <= CNT_WIDTH'(sat_add(64'(block_errors), 64'd1, CMAX));
                if (blk_sum > worst_block_errs)
                    worst_block_errs <= blk_sum;
                if (s2_lerr)
                    length_error <= 1'b1;
            end else begin
                acc <= blk_sum;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_ber_tester_dout_checker.sv
// Bench for the DOUT checker: a 64-bit and an 8-bit counter build share one stimulus stream;
// a reference model pushes expected statistics per block end and a monitor compares them.
module tb_ldpc_ber_tester_dout_checker;
    localparam int DW = 128;
    localparam int KW = DW / 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [LW-1:0] block_beats = LW'(2);

    ldpc_ber_tester_dout_checker_if #(.DATA_WIDTH(DW)) dif ();
    ldpc_ber_tester_dout_checker_if #(.DATA_WIDTH(DW)) dif8 ();

    assign dif8.tdata  = dif.tdata;
    assign dif8.tkeep  = dif.tkeep;
    assign dif8.tlast  = dif.tlast;
    assign dif8.tvalid = dif.tvalid;

    logic        fin, fin8, le, le8;
    logic [63:0] be, bc, ke, kc, we;
    logic [7:0]  be8, bc8, ke8, kc8, we8;

    ldpc_ber_tester_dout_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(64), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .block_beats(block_beats), .dout(dif),
        .dout_finish(fin), .bit_errors(be), .bits_checked(bc), .block_errors(ke),
        .blocks_checked(kc), .worst_block_errs(we), .length_error(le));

    ldpc_ber_tester_dout_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(8), .LEN_WIDTH(LW)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .block_beats(block_beats), .dout(dif8),
        .dout_finish(fin8), .bit_errors(be8), .bits_checked(bc8), .block_errors(ke8),
        .blocks_checked(kc8), .worst_block_errs(we8), .length_error(le8));

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned bit_errs, bits, blk_errs, blks, worst;
        bit              lerr;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    n_last_sent = 0;
    int    n_finish = 0;

    longint unsigned m_bit_errs, m_bits, m_blk_errs, m_blks, m_worst, m_sum;
    bit              m_lerr, m_in_block;
    int              m_cnt, m_len_exp;

    function automatic longint unsigned sat8(longint unsigned v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic snap_t cur_snap();
        snap_t s;
        s.bit_errs = m_bit_errs; s.bits = m_bits; s.blk_errs = m_blk_errs;
        s.blks = m_blks; s.worst = m_worst; s.lerr = m_lerr;
        return s;
    endfunction

    task automatic model_clear();
        m_bit_errs = 0; m_bits = 0; m_blk_errs = 0; m_blks = 0; m_worst = 0;
        m_sum = 0; m_lerr = 0; m_in_block = 0; m_cnt = 0; m_len_exp = 0;
    endtask

    // Behavioural view: every kept '1' is an error, a block is the run of beats up to tlast.
    task automatic model_beat(logic [DW-1:0] d, logic [KW-1:0] k, bit last, bit discard);
        int errs, bits;
        errs = 0; bits = 0;
        if (!discard) begin
            for (int b = 0; b < KW; b++)
                if (k[b]) begin
                    errs += $countones(d[b*8 +: 8]);
                    bits += 8;
                end
            m_bit_errs += errs;
            m_bits     += bits;
            if (!m_in_block) begin
                m_len_exp = int'(block_beats);
                m_cnt = 0;
                m_sum = 0;
            end
            m_cnt++;
            m_sum += errs;
            if (last) begin
                if (m_cnt != m_len_exp) m_lerr = 1;
                m_blks++;
                if (m_sum != 0) m_blk_errs++;
                if (m_sum > m_worst) m_worst = m_sum;
                m_in_block = 0;
            end else begin
                m_in_block = 1;
            end
        end
        if (last) exp_q.push_back(cur_snap());
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(logic [DW-1:0] d, logic [KW-1:0] k, bit last, bit discard);
        dif.tdata = d; dif.tkeep = k; dif.tlast = last; dif.tvalid = 1'b1;
        @(negedge clk);
        check("tready_high", 64'(dif.tready), 64'd1);
        model_beat(d, k, last, discard);
        if (last) n_last_sent++;
        @(posedge clk);
        #1;
        dif.tvalid = 1'b0; dif.tlast = 1'b0; dif.tdata = '1; dif.tkeep = '1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        int mode;
        mode = $urandom_range(0, 3);
        d = {$urandom, $urandom, $urandom, $urandom};
        case (mode)
            0: d = '0;
            1: begin d = '0; d[$urandom_range(0, DW-1)] = 1'b1; end
            2: d = d & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
            default: ;
        endcase
        return d;
    endfunction

    // Statistics of a block end appear on the third falling edge after its dout_finish.
    logic [2:0] fin_d = 3'b0;
    always @(negedge clk) begin
        if (reset) begin
            fin_d = 3'b0;
        end else begin
            if (fin_d[2]) begin
                snap_t s;
                if (exp_q.size() == 0) begin
                    check("unexpected_block_end", 64'd1, 64'd0);
                end else begin
                    s = exp_q.pop_front();
                    check("bit_errors", be, s.bit_errs);
                    check("bits_checked", bc, s.bits);
                    check("block_errors", ke, s.blk_errs);
                    check("blocks_checked", kc, s.blks);
                    check("worst_block_errs", we, s.worst);
                    check("length_error", 64'(le), 64'(s.lerr));
                    check("bit_errors_w8", 64'(be8), sat8(s.bit_errs));
                    check("bits_checked_w8", 64'(bc8), sat8(s.bits));
                    check("block_errors_w8", 64'(ke8), sat8(s.blk_errs));
                    check("blocks_checked_w8", 64'(kc8), sat8(s.blks));
                    check("worst_block_errs_w8", 64'(we8), sat8(s.worst));
                    check("length_error_w8", 64'(le8), 64'(s.lerr));
                end
            end
            fin_d = {fin_d[1:0], fin};
            if (fin) n_finish++;
        end
    end

    task automatic check_all_zero(string tag);
        check({tag, "_bit_errors"}, be, 64'd0);
        check({tag, "_bits_checked"}, bc, 64'd0);
        check({tag, "_block_errors"}, ke, 64'd0);
        check({tag, "_blocks_checked"}, kc, 64'd0);
        check({tag, "_worst"}, we, 64'd0);
        check({tag, "_length_error"}, 64'(le), 64'd0);
        check({tag, "_bits_checked_w8"}, 64'(bc8), 64'd0);
        check({tag, "_tready"}, 64'(dif.tready), 64'd0);
        check({tag, "_tready_w8"}, 64'(dif8.tready), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int bb, len;

        dif.tvalid = 1'b0; dif.tlast = 1'b0; dif.tdata = '1; dif.tkeep = '1;
        model_clear();
        idle(3);
        check_all_zero("reset");
        reset = 1'b0;
        idle(1);
        check("tready_after_reset", 64'(dif.tready), 64'd1);

        block_beats = LW'(2);
        for (int i = 0; i < 10; i++) begin
            send_beat('0, '1, 1'b0, 1'b0);
            send_beat('0, '1, 1'b1, 1'b0);
        end
        idle(2);

        d = '0; d[2:0] = 3'b101;
        send_beat(d, '1, 1'b0, 1'b0);
        d = '0; d[DW-1] = 1'b1;
        send_beat(d, '1, 1'b1, 1'b0);

        send_beat('0, '1, 1'b0, 1'b0);
        send_beat('1, KW'(1), 1'b1, 1'b0);

        block_beats = LW'(4);
        for (int i = 0; i < 3; i++) send_beat('0, '1, (i == 2), 1'b0);
        for (int i = 0; i < 4; i++) send_beat('0, '1, (i == 3), 1'b0);

        // Two all-ones beats push one block past 255 errors in the narrow build.
        block_beats = LW'(2);
        send_beat('1, '1, 1'b0, 1'b0);
        send_beat('1, '1, 1'b1, 1'b0);
        idle(5);

        // Clear mid-block: the following beats form a fresh block.
        block_beats = LW'(4);
        send_beat('0, '1, 1'b0, 1'b0);
        send_beat('0, '1, 1'b0, 1'b0);
        idle(4);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) send_beat('1, KW'(3), (i == 3), 1'b0);
        idle(5);

        // Erroneous block in stage 2 plus a block end in the clear cycle are both dropped.
        block_beats = LW'(1);
        model_clear();
        send_beat('1, '1, 1'b1, 1'b1);
        idle(1);
        clear = 1'b1;
        send_beat('1, '1, 1'b1, 1'b1);
        clear = 1'b0;
        idle(5);

        for (int blk = 0; blk < 300; blk++) begin
            bb = $urandom_range(1, 5);
            block_beats = LW'(bb);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : bb;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if (i == 1 && $urandom_range(0, 1) == 1) block_beats = LW'($urandom_range(1, 5));
                send_beat(rand_data(), ($urandom_range(0, 3) == 0) ? KW'($urandom) : '1,
                          (i == len - 1), 1'b0);
            end
        end
        idle(6);

        // Reset in the middle of a block.
        block_beats = LW'(4);
        send_beat('1, '1, 1'b0, 1'b0);
        send_beat('1, '1, 1'b0, 1'b0);
        dif.tvalid = 1'b1; dif.tlast = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_all_zero("midblock_reset");
        check("finish_in_reset", 64'(fin), 64'd0);
        idle(2);
        dif.tvalid = 1'b0; dif.tlast = 1'b0;
        reset = 1'b0;
        model_clear();
        idle(1);
        check("tready_after_reset2", 64'(dif.tready), 64'd1);
        block_beats = LW'(1);
        d = '0; d[7:0] = 8'h0f;
        send_beat(d, '1, 1'b1, 1'b0);
        idle(6);

        check("pending_expectations", 64'(exp_q.size()), 64'd0);
        check("finish_pulses", 64'(n_finish), 64'(n_last_sent));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
